mem_wb_regfile: RTL and testbench

MEM/WB pipeline register, writeback source selection and 8×8 general-purpose register file for the 8-bit RISC core. Captures the four candidate writeback values (ALU result, data-memory read, MOV operand, effective address) and the destination from the memory stage. Selects the writeback value and commits it to the register file. Provides two bypassed asynchronous read ports to decode.

---
 rtl/mem_wb_regfile_pkg.sv | 16 +
 rtl/mem_wb_regfile_wb_sel.sv | 25 ++
 rtl/mem_wb_regfile.sv | 130 +++++++++++++
 tb/tb_mem_wb_regfile.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_regfile_pkg.sv
// Shared core constants and the writeback-source encoding.
// Decode and execute use the same encoding when they drive wbcr.
package mem_wb_regfile_pkg;

    localparam int DW   = 8;
    localparam int NREG = 8;
    localparam int AW   = 3;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_DM  = 2'd1,
        WB_MOV = 2'd2,
        WB_EA  = 2'd3
    } wbcr_e;

endpackage

// File: rtl/mem_wb_regfile_wb_sel.sv
// Combinational 4:1 writeback source select; zero latency, no flow control.
module mem_wb_regfile_wb_sel #(
    parameter int DW = mem_wb_regfile_pkg::DW
) (
    input  mem_wb_regfile_pkg::wbcr_e wbcr_i,
    input  logic [DW-1:0]             alud_i,
    input  logic [DW-1:0]             dm_i,
    input  logic [DW-1:0]             mov_i,
    input  logic [DW-1:0]             ea2_i,
    output logic [DW-1:0]             data_o
);
    import mem_wb_regfile_pkg::*;

    always_comb begin
        data_o = alud_i;
        case (wbcr_i)
            WB_ALU:  data_o = alud_i;
            WB_DM:   data_o = dm_i;
            WB_MOV:  data_o = mov_i;
            WB_EA:   data_o = ea2_i;
            default: data_o = alud_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_regfile.sv
// MEM/WB pipeline register, writeback select and 8x8 register file with bypassed reads.
// One cycle MEM->WB, array commits the edge after; stall holds the register, flush bubbles it.
module mem_wb_regfile #(
    parameter int DW   = mem_wb_regfile_pkg::DW,
    parameter int NREG = mem_wb_regfile_pkg::NREG,
    parameter int AW   = mem_wb_regfile_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_alud,
    input  logic [DW-1:0] in_dm,
    input  logic [DW-1:0] in_mov,
    input  logic [DW-1:0] in_ea2,
    input  logic [1:0]    in_wbcr,
    input  logic [AW-1:0] in_rd,
    input  logic          in_regwrite,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] ra_data,
    output logic [DW-1:0] rb_data,
    output logic          wb_valid,
    output logic          wb_we,
    output logic [AW-1:0] wb_rd,
    output logic [DW-1:0] wb_data
);
    import mem_wb_regfile_pkg::*;

    logic          valid_q, valid_d;
    logic [DW-1:0] alud_q, alud_d;
    logic [DW-1:0] dm_q, dm_d;
    logic [DW-1:0] mov_q, mov_d;
    logic [DW-1:0] ea2_q, ea2_d;
    wbcr_e         wbcr_q, wbcr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic          regwrite_q, regwrite_d;

    logic [DW-1:0] regs_q [NREG];

    // Flush only clears valid; payload fields just hold, as they are don't-care.
    always_comb begin
        valid_d    = valid_q;
        alud_d     = alud_q;
        dm_d       = dm_q;
        mov_d      = mov_q;
        ea2_d      = ea2_q;
        wbcr_d     = wbcr_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d    = in_valid;
            alud_d     = in_alud;
            dm_d       = in_dm;
            mov_d      = in_mov;
            ea2_d      = in_ea2;
            wbcr_d     = wbcr_e'(in_wbcr);
            rd_d       = in_rd;
            regwrite_d = in_regwrite;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            alud_q     <= '0;
            dm_q       <= '0;
            mov_q      <= '0;
            ea2_q      <= '0;
            wbcr_q     <= WB_ALU;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            alud_q     <= alud_d;
            dm_q       <= dm_d;
            mov_q      <= mov_d;
            ea2_q      <= ea2_d;
            wbcr_q     <= wbcr_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
        end
    end

    mem_wb_regfile_wb_sel #(.DW(DW)) u_wb_sel (
        .wbcr_i (wbcr_q),
        .alud_i (alud_q),
        .dm_i   (dm_q),
        .mov_i  (mov_q),
        .ea2_i  (ea2_q),
        .data_o (wb_data)
    );

    assign wb_valid = valid_q;
    assign wb_rd    = rd_q;
    assign wb_we    = valid_q & regwrite_q & (rd_q != '0);

    // R0 is never written because wb_we excludes rd==0, so it stays at its reset zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_we) begin
            regs_q[rd_q] <= wb_data;
        end
    end

    always_comb begin
        ra_data = regs_q[ra_addr];
        if (ra_addr == '0) begin
            ra_data = '0;
        end else if (wb_we && (ra_addr == rd_q)) begin
            ra_data = wb_data;
        end
    end

    always_comb begin
        rb_data = regs_q[rb_addr];
        if (rb_addr == '0) begin
            rb_data = '0;
        end else if (wb_we && (rb_addr == rd_q)) begin
            rb_data = wb_data;
        end
    end

endmodule

// File: tb/tb_mem_wb_regfile.sv
// Scoreboard bench for the MEM/WB register and register file.
module tb_mem_wb_regfile;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall, flush;
    logic       in_valid, in_regwrite;
    logic [7:0] in_alud, in_dm, in_mov, in_ea2;
    logic [1:0] in_wbcr;
    logic [2:0] in_rd;
    logic [2:0] ra_addr, rb_addr;
    logic [7:0] ra_data, rb_data;
    logic       wb_valid, wb_we;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       v;
        logic       we;
        logic [2:0] rd;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t ex;

    mem_wb_regfile dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_alud     (in_alud),
        .in_dm       (in_dm),
        .in_mov      (in_mov),
        .in_ea2      (in_ea2),
        .in_wbcr     (in_wbcr),
        .in_rd       (in_rd),
        .in_regwrite (in_regwrite),
        .ra_addr     (ra_addr),
        .rb_addr     (rb_addr),
        .ra_data     (ra_data),
        .rb_data     (rb_data),
        .wb_valid    (wb_valid),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data)
    );

    always #5 clk = ~clk;

    // Drive one memory-stage instruction and push what WB must show after the next edge.
    task automatic issue(input logic v, input logic rw, input logic [2:0] rd,
                         input logic [1:0] sel, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] m, input logic [7:0] e, input logic push);
        exp_t x;
        in_valid    = v;
        in_regwrite = rw;
        in_rd       = rd;
        in_wbcr     = sel;
        in_alud     = a;
        in_dm       = d;
        in_mov      = m;
        in_ea2      = e;
        x.v  = v;
        x.we = v & rw & (rd != 3'd0);
        x.rd = rd;
        case (sel)
            2'd0:    x.data = a;
            2'd1:    x.data = d;
            2'd2:    x.data = m;
            default: x.data = e;
        endcase
        if (push) sb.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        issue(1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        ra_addr = 3'd0; rb_addr = 3'd0;
        #12;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ra_addr = 3'(i);
            rb_addr = 3'(7 - i);
            #1;
            checks++;
            if (ra_data !== 8'h00 || rb_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_read addr=%0d ra=%h rb=%h expected 00", i, ra_data, rb_data);
            end
        end
        checks++;
        if (wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_data !== 8'h00 || wb_rd !== 3'd0) begin
            errors++;
            $display("FAIL reset_wb valid=%b we=%b rd=%0d data=%h expected all 0",
                     wb_valid, wb_we, wb_rd, wb_data);
        end
        step();
    endtask

    task automatic test_src_sel();
        for (int w = 0; w < 4; w++) begin
            issue(1'b1, 1'b1, 3'd3, 2'(w), 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
            step();
            ex = sb.pop_front();
            checks++;
            if (wb_data !== ex.data || wb_we !== ex.we || wb_rd !== ex.rd || wb_valid !== ex.v) begin
                errors++;
                $display("FAIL src_sel wbcr=%0d got v=%b we=%b rd=%0d data=%h expected v=%b we=%b rd=%0d data=%h",
                         w, wb_valid, wb_we, wb_rd, wb_data, ex.v, ex.we, ex.rd, ex.data);
            end
        end
        issue(1'b0, 1'b1, 3'd3, 2'd0, 8'hEE, 8'h00, 8'h00, 8'h00, 1'b1);
        ra_addr = 3'd3; rb_addr = 3'd3;
        step();
        ex = sb.pop_front();
        checks++;
        if (wb_we !== ex.we || wb_valid !== ex.v) begin
            errors++;
            $display("FAIL bubble_we got v=%b we=%b expected v=%b we=%b", wb_valid, wb_we, ex.v, ex.we);
        end
        checks++;
        if (ra_data !== 8'h44 || rb_data !== 8'h44) begin
            errors++;
            $display("FAIL src_sel_r3 ra=%h rb=%h expected 44", ra_data, rb_data);
        end
    endtask

    task automatic test_bypass();
        logic [7:0] vals [3];
        vals[0] = 8'hA5; vals[1] = 8'h5C; vals[2] = 8'hC3;
        ra_addr = 3'd5; rb_addr = 3'd5;
        for (int k = 0; k < 3; k++) begin
            issue(1'b1, 1'b1, 3'd5, 2'd0, vals[k], 8'h00, 8'h00, 8'h00, 1'b1);
            step();
            ex = sb.pop_front();
            checks++;
            if (wb_data !== ex.data || wb_we !== ex.we) begin
                errors++;
                $display("FAIL bypass_wb k=%0d data=%h we=%b expected data=%h we=%b",
                         k, wb_data, wb_we, ex.data, ex.we);
            end
            checks++;
            if (ra_data !== vals[k] || rb_data !== vals[k]) begin
                errors++;
                $display("FAIL bypass_read k=%0d ra=%h rb=%h expected %h", k, ra_data, rb_data, vals[k]);
            end
        end
        issue(1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        step();
        ex = sb.pop_front();
        checks++;
        if (wb_we !== 1'b0 || ra_data !== 8'hC3 || rb_data !== 8'hC3) begin
            errors++;
            $display("FAIL bypass_array we=%b ra=%h rb=%h expected we=0 data c3", wb_we, ra_data, rb_data);
        end
    endtask

    task automatic test_r0();
        ra_addr = 3'd0; rb_addr = 3'd3;
        issue(1'b1, 1'b1, 3'd0, 2'd0, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1);
        step();
        ex = sb.pop_front();
        checks++;
        if (wb_we !== ex.we || wb_data !== ex.data || wb_valid !== ex.v) begin
            errors++;
            $display("FAIL r0_wb we=%b data=%h v=%b expected we=%b data=%h v=%b",
                     wb_we, wb_data, wb_valid, ex.we, ex.data, ex.v);
        end
        checks++;
        if (ra_data !== 8'h00 || rb_data !== 8'h44) begin
            errors++;
            $display("FAIL r0_read ra=%h rb=%h expected ra=00 rb=44", ra_data, rb_data);
        end
        issue(1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        step();
        void'(sb.pop_front());
        checks++;
        if (ra_data !== 8'h00) begin
            errors++;
            $display("FAIL r0_after ra=%h expected 00", ra_data);
        end
    endtask

    task automatic test_stall_flush();
        issue(1'b1, 1'b1, 3'd6, 2'd2, 8'h00, 8'h00, 8'h66, 8'h00, 1'b1);
        step();
        ex = sb.pop_front();
        stall = 1'b1;
        ra_addr = 3'd6; rb_addr = 3'd7;
        for (int c = 0; c < 3; c++) begin
            issue(1'b1, 1'b1, 3'd7, 2'(c), 8'h71, 8'h72, 8'h73, 8'h74, 1'b0);
            step();
            checks++;
            if (wb_valid !== ex.v || wb_rd !== ex.rd || wb_data !== ex.data || wb_we !== ex.we) begin
                errors++;
                $display("FAIL stall_hold c=%0d v=%b rd=%0d data=%h we=%b expected v=%b rd=%0d data=%h we=%b",
                         c, wb_valid, wb_rd, wb_data, wb_we, ex.v, ex.rd, ex.data, ex.we);
            end
        end
        flush = 1'b1;
        step();
        checks++;
        if (wb_valid !== 1'b0 || wb_we !== 1'b0 || ra_data !== 8'h66 || rb_data !== 8'h00) begin
            errors++;
            $display("FAIL stall_flush v=%b we=%b ra=%h rb=%h expected v=0 we=0 ra=66 rb=00",
                     wb_valid, wb_we, ra_data, rb_data);
        end
        stall = 1'b0; flush = 1'b0;
        // Flush right behind a live WB instruction must not cancel its commit.
        issue(1'b1, 1'b1, 3'd4, 2'd3, 8'h00, 8'h00, 8'h00, 8'h4D, 1'b1);
        step();
        void'(sb.pop_front());
        flush = 1'b1;
        ra_addr = 3'd4;
        issue(1'b1, 1'b1, 3'd4, 2'd0, 8'h99, 8'h00, 8'h00, 8'h00, 1'b0);
        step();
        flush = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || ra_data !== 8'h4D) begin
            errors++;
            $display("FAIL flush_commit v=%b ra=%h expected v=0 ra=4d", wb_valid, ra_data);
        end
        issue(1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        step();
    endtask

    task automatic test_async_reset();
        issue(1'b1, 1'b1, 3'd2, 2'd0, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b1);
        ra_addr = 3'd2; rb_addr = 3'd3;
        step();
        ex = sb.pop_front();
        checks++;
        if (wb_we !== ex.we || wb_data !== ex.data || ra_data !== 8'h5A) begin
            errors++;
            $display("FAIL pre_reset we=%b data=%h ra=%h expected we=%b data=%h ra=5a",
                     wb_we, wb_data, ra_data, ex.we, ex.data);
        end
        issue(1'b0, 1'b0, 3'd0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ra_data !== 8'h00 || rb_data !== 8'h00 || wb_valid !== 1'b0 || wb_we !== 1'b0 ||
            wb_rd !== 3'd0 || wb_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset ra=%h rb=%h v=%b we=%b rd=%0d data=%h expected all 0",
                     ra_data, rb_data, wb_valid, wb_we, wb_rd, wb_data);
        end
        step();
        #2;
        rst = 1'b0;
        step();
        checks++;
        if (ra_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_lost_write ra=%h expected 00", ra_data);
        end
        sb.delete();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_src_sel();
        test_bypass();
        test_r0();
        test_stall_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
